// File: rtl/arbpuf_xor_eval.sv
// arbpuf_xor_eval: multi-chain arbiter-PUF evaluator with launch/settle/recover sequencing
// and per-chain majority voting over repeated evaluations.
`default_nettype none

module arbpuf_chain #(
    parameter int STAGES = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              launch_i,
    input  logic              clear_i,
    input  logic [STAGES-1:0] challenge_i,
    output logic              arb_o
);
    logic top_w, bot_w, swap_w;
    logic arb_q, done_q;

    // Each set challenge bit crosses the two racing paths at that stage.
    always_comb begin
        top_w  = launch_i;
        bot_w  = launch_i;
        swap_w = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (challenge_i[i]) begin
                swap_w = top_w;
                top_w  = bot_w;
                bot_w  = swap_w;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (clear_i) begin
            arb_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (!done_q && (top_w || bot_w)) begin
            arb_q  <= top_w && !bot_w;
            done_q <= 1'b1;
        end
    end

    assign arb_o = arb_q;
endmodule

module arbpuf_xor_eval #(
    parameter int STAGES        = 32,
    parameter int CHAINS        = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int VOTES         = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [STAGES-1:0] challenge_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [CHAINS-1:0] resp_o,
    output logic              xor_o,
    output logic [CHAINS-1:0] stable_o
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int VW = $clog2(VOTES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [VW-1:0] VOTE_HALF   = VW'(VOTES / 2);
    localparam logic [VW-1:0] VOTE_ALL    = VW'(VOTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        SETTLE  = 3'd2,
        SAMPLE  = 3'd3,
        RECOVER = 3'd4,
        DECIDE  = 3'd5
    } state_t;

    state_t            state_q;
    logic [STAGES-1:0] chal_q;
    logic              launch_q, clear_q;
    logic [SW-1:0]     settle_q;
    logic [VW-1:0]     vote_q;
    logic [VW-1:0]     ones_q [CHAINS];
    logic              busy_q, valid_q, xor_q;
    logic [CHAINS-1:0] resp_q, stable_q;
    logic [CHAINS-1:0] sync1_q, sync2_q;
    logic [CHAINS-1:0] arb_raw;
    logic [CHAINS-1:0] resp_d, stable_d;

    for (genvar k = 0; k < CHAINS; k++) begin : g_chain
        arbpuf_chain #(.STAGES(STAGES)) u_chain (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .launch_i    (launch_q),
            .clear_i     (clear_q),
            .challenge_i (chal_q),
            .arb_o       (arb_raw[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= arb_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        resp_d   = '0;
        stable_d = '0;
        for (int k = 0; k < CHAINS; k++) begin
            resp_d[k]   = ones_q[k] > VOTE_HALF;
            stable_d[k] = (ones_q[k] == '0) || (ones_q[k] == VOTE_ALL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            chal_q   <= '0;
            launch_q <= 1'b0;
            clear_q  <= 1'b1;
            settle_q <= '0;
            vote_q   <= '0;
            for (int k = 0; k < CHAINS; k++) ones_q[k] <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            resp_q   <= '0;
            xor_q    <= 1'b0;
            stable_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        chal_q <= challenge_i;
                        vote_q <= '0;
                        for (int k = 0; k < CHAINS; k++) ones_q[k] <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    launch_q <= 1'b1;
                    clear_q  <= 1'b0;
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_q <= SAMPLE;
                    else                         settle_q <= settle_q + 1'b1;
                end
                SAMPLE: begin
                    for (int k = 0; k < CHAINS; k++) ones_q[k] <= ones_q[k] + VW'(sync2_q[k]);
                    launch_q <= 1'b0;
                    clear_q  <= 1'b1;
                    settle_q <= '0;
                    state_q  <= RECOVER;
                end
                RECOVER: begin
                    if (settle_q == SETTLE_LAST) begin
                        clear_q <= 1'b0;
                        if (vote_q == VOTE_LAST) begin
                            state_q <= DECIDE;
                        end else begin
                            vote_q  <= vote_q + 1'b1;
                            state_q <= LAUNCH;
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                DECIDE: begin
                    resp_q   <= resp_d;
                    stable_q <= stable_d;
                    xor_q    <= ^resp_d;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign resp_o   = resp_q;
    assign xor_o    = xor_q;
    assign stable_o = stable_q;
endmodule

`default_nettype wire

// File: tb/tb_arbpuf_xor_eval.sv
// tb_arbpuf_xor_eval: drives the evaluator with behavioural chain responses (forced onto the
// raw arbiter bits) and compares every cycle against a request-level model.
`default_nettype none

module tb_arbpuf_xor_eval;
    localparam int S   = 8;
    localparam int V   = 5;
    localparam int P   = 2 * S + 2;
    localparam int LAT = V * P + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, start_s = 1'b0;
    logic [31:0] chal = '0;
    logic        busy, valid, xr, busy_s, valid_s, xr_s;
    logic [3:0]  resp, stab, resp_s, stab_s;

    arbpuf_xor_eval u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .challenge_i(chal),
        .busy_o(busy), .valid_o(valid), .resp_o(resp), .xor_o(xr), .stable_o(stab)
    );

    arbpuf_xor_eval #(.STAGES(32), .CHAINS(4), .SETTLE_CYCLES(3), .VOTES(1)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .challenge_i(chal),
        .busy_o(busy_s), .valid_o(valid_s), .resp_o(resp_s), .xor_o(xr_s), .stable_o(stab_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural chain: bit vector returned by all chains for a challenge on vote v.
    function automatic logic [3:0] chain_bits(input int m, input logic [31:0] c, input int v);
        logic [4:0] pat;
        logic [3:0] b;
        pat = 5'b01101;
        b   = '0;
        case (m)
            0: b = (c == 32'hA5A5_A5A5) ? 4'b1101 : 4'b0010;
            1: b = {3'b000, pat[v]};
            3: b = c[3:0] ^ ((v < 2) ? 4'b1000 : 4'b0000);
            default: b = '0;
        endcase
        return b;
    endfunction

    int          mode = 0;
    int          req_mode = 0;
    int          gedge = 0;
    int          acc = -1;
    logic        exp_busy = 0, exp_valid = 0, exp_xor = 0, nxt_xor;
    logic [3:0]  exp_resp = '0, exp_stab = '0, nxt_resp, nxt_stab;
    logic [3:0]  raw_model = '0;

    task automatic predict(input logic [31:0] c, input int m);
        logic [3:0] b;
        int cnt;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            for (int v = 0; v < V; v++) begin
                b = chain_bits(m, c, v);
                cnt += int'(b[k]);
            end
            nxt_resp[k] = (cnt > V / 2);
            nxt_stab[k] = (cnt == 0) || (cnt == V);
        end
        nxt_xor = ^nxt_resp;
    endtask

    // Request-level model: acceptance only when idle, result LAT edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc = -1; exp_busy = 0; exp_valid = 0;
            exp_resp = '0; exp_stab = '0; exp_xor = 0;
        end else begin
            gedge++;
            exp_valid = 0;
            if (acc >= 0 && gedge == acc + LAT) begin
                exp_resp = nxt_resp; exp_stab = nxt_stab; exp_xor = nxt_xor;
                exp_valid = 1; exp_busy = 0;
            end else if (start && (acc < 0 || gedge > acc + LAT)) begin
                acc = gedge; req_mode = mode; exp_busy = 1;
                predict(chal, mode);
            end
        end
    end

    always @(negedge clk) begin : p_force
        int v;
        v = (acc >= 0 && gedge > acc) ? (gedge - acc - 1) / P : 0;
        if (v >= V) v = V - 1;
        raw_model = chain_bits(req_mode, u_dut.g_chain[0].u_chain.challenge_i, v);
        force u_dut.arb_raw = raw_model;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",   32'(busy),  32'(exp_busy));
            check("valid",  32'(valid), 32'(exp_valid));
            check("resp",   32'(resp),  32'(exp_resp));
            check("xor",    32'(xr),    32'(exp_xor));
            check("stable", 32'(stab),  32'(exp_stab));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] c, input int m, output int first);
        mode = m; chal = c; start = 1'b1;
        tick();
        start = 1'b0;
        first = -1;
        for (int e = 1; e <= 200 && first < 0; e++) begin
            tick();
            if (valid) first = e;
        end
    endtask

    int first, v1, v2, vcount;

    initial begin
        force u_small.arb_raw = 4'b0110;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_launch", 32'(u_dut.launch_q), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Deterministic chains under the reference challenge.
        run_req(32'hA5A5_A5A5, 0, first);
        check("det_latency", first, LAT);
        check("det_resp", 32'(resp), 32'h0000_000D);
        check("det_xor", 32'(xr), 1);
        check("det_stable", 32'(stab), 32'h0000_000F);
        check("det_busy", 32'(busy), 0);
        tick();

        // Challenge altered after acceptance, extra starts while busy.
        mode = 0; chal = 32'hA5A5_A5A5; start = 1'b1;
        tick();
        start = 1'b0; chal = 32'hFFFF_FFFF;
        first = -1; vcount = 0;
        for (int e = 1; e <= 150; e++) begin
            start = (e == 10 || e == 50);
            tick();
            if (valid && first < 0) first = e;
            if (valid) vcount++;
        end
        start = 1'b0;
        check("busy_start_latency", first, LAT);
        check("busy_start_pulses", vcount, 1);
        check("busy_start_resp", 32'(resp), 32'h0000_000D);

        // Noisy chain 0.
        run_req(32'h0F0F_0F0F, 1, first);
        check("noisy_latency", first, LAT);
        check("noisy_resp", 32'(resp), 32'h0000_0001);
        check("noisy_xor", 32'(xr), 1);
        check("noisy_stable", 32'(stab), 32'h0000_000E);
        tick();

        // start held high across DECIDE launches the next request immediately.
        mode = 3; chal = 32'h0000_000B; start = 1'b1;
        v1 = -1; v2 = -1;
        for (int e = 0; e <= 260 && v2 < 0; e++) begin
            tick();
            if (e == 92) start = 1'b0;
            if (valid && v1 < 0) begin
                v1 = e;
                check("held_resp", 32'(resp), 32'h0000_000B);
                check("held_stable", 32'(stab), 32'h0000_0007);
                check("held_xor", 32'(xr), 1);
            end else if (valid) begin
                v2 = e;
            end
        end
        start = 1'b0;
        check("held_first", v1, LAT);
        check("held_second", v2, 2 * LAT + 1);
        tick();

        // Reset during the settle phase of the second vote.
        mode = 0; chal = 32'hA5A5_A5A5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) tick();
        check("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_resp", 32'(resp), 0);
        check("mid_rst_stable", 32'(stab), 0);
        check("mid_rst_xor", 32'(xr), 0);
        check("mid_rst_launch", 32'(u_dut.launch_q), 0);
        check("mid_rst_clear", 32'(u_dut.clear_q), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_req(32'h1234_5678, 0, first);
        check("post_rst_latency", first, LAT);
        check("post_rst_resp", 32'(resp), 32'h0000_0002);
        check("post_rst_stable", 32'(stab), 32'h0000_000F);
        tick();

        // Single vote, minimum settle.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        first = -1;
        for (int e = 1; e <= 50 && first < 0; e++) begin
            tick();
            if (valid_s) first = e;
        end
        check("small_latency", first, 9);
        check("small_resp", 32'(resp_s), 32'h0000_0006);
        check("small_xor", 32'(xr_s), 0);
        check("small_stable", 32'(stab_s), 32'h0000_000F);
        check("small_busy", 32'(busy_s), 0);
        tick();
        check("small_valid_pulse", 32'(valid_s), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

`default_nettype wire
